// File: rtl/bus_protocol_monitor_if.sv
// Bundle of the monitored bus signals for all channels. The bus model drives
// through the master modport; the protocol monitor only observes via slave.
interface bus_protocol_monitor_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 8
) ();
    logic [NUM_CH-1:0]        active;
    logic [NUM_CH-1:0]        ready;
    logic [NUM_CH-1:0]        data_oe;
    logic [NUM_CH*DATA_W-1:0] data;

    modport master (output active, output ready, output data_oe, output data);
    modport slave  (input active, input ready, input data_oe, input data);
endinterface

// File: rtl/bus_protocol_monitor.sv
// Passive multi-channel handshake checker. Each channel keeps a short history
// of active/ready and flags four rules: data driven outside a transfer, stall
// timeout, ready raised from idle, and ready raised right after active fell.
module bus_protocol_monitor #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned STALL_MAX = 5,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mon_en,
    input  logic                       clr,
    bus_protocol_monitor_if.slave      bus,
    output logic [NUM_CH-1:0]          err_pulse,
    output logic [4*NUM_CH-1:0]        err_sticky,
    output logic [NUM_CH*CNT_W-1:0]    err_cnt,
    output logic [NUM_CH*CNT_W-1:0]    beat_cnt,
    output logic [NUM_CH*DATA_W-1:0]   last_data
);
    localparam int unsigned SW = $clog2(STALL_MAX + 1);
    localparam logic [SW-1:0] StallMax = SW'(STALL_MAX);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [NUM_CH-1:0]             prev_valid_q, prev_valid_d;
    logic [NUM_CH-1:0]             act_q, act_d;
    logic [NUM_CH-1:0]             rdy_q, rdy_d;
    logic [NUM_CH-1:0]             fell_q, fell_d;
    logic [NUM_CH-1:0][SW-1:0]     stall_cnt_q, stall_cnt_d;
    logic [NUM_CH-1:0]             err_pulse_q, err_pulse_d;
    logic [NUM_CH-1:0][3:0]        err_sticky_q, err_sticky_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [NUM_CH-1:0][DATA_W-1:0] last_data_q, last_data_d;

    logic [NUM_CH-1:0][3:0]        viol;
    logic [NUM_CH-1:0]             beat;

    // Rule evaluation on the current sample; bit r-1 of viol[c] is rule r.
    always_comb begin
        viol = '0;
        beat = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (mon_en) begin
                viol[c][0] = (!bus.active[c] || !bus.ready[c]) && bus.data_oe[c];
                viol[c][1] = prev_valid_q[c] && (stall_cnt_q[c] == StallMax) && bus.active[c];
                viol[c][2] = prev_valid_q[c] && !act_q[c] && !rdy_q[c] && bus.ready[c];
                viol[c][3] = prev_valid_q[c] && fell_q[c] && bus.ready[c];
                beat[c]    = bus.active[c] && bus.ready[c] && bus.data_oe[c];
            end
        end
    end

    // Next-state for history, flags and counters; clr wins over same-cycle updates.
    always_comb begin
        prev_valid_d = prev_valid_q;
        act_d        = act_q;
        rdy_d        = rdy_q;
        fell_d       = fell_q;
        stall_cnt_d  = stall_cnt_q;
        err_pulse_d  = err_pulse_q;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        last_data_d  = last_data_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            // History tracks the bus even while checking is disabled.
            prev_valid_d[c] = 1'b1;
            act_d[c]        = bus.active[c];
            rdy_d[c]        = bus.ready[c];
            fell_d[c]       = act_q[c] && !bus.active[c];
            if (bus.active[c] && !bus.ready[c]) begin
                stall_cnt_d[c] = (stall_cnt_q[c] == StallMax) ? StallMax
                                                              : stall_cnt_q[c] + SW'(1);
            end else begin
                stall_cnt_d[c] = '0;
            end

            err_pulse_d[c] = |viol[c];
            if (clr) begin
                err_sticky_d[c] = '0;
                err_cnt_d[c]    = '0;
                beat_cnt_d[c]   = '0;
            end else begin
                err_sticky_d[c] = err_sticky_q[c] | viol[c];
                if (|viol[c] && err_cnt_q[c] != CntMax) begin
                    err_cnt_d[c] = err_cnt_q[c] + CNT_W'(1);
                end
                if (beat[c] && beat_cnt_q[c] != CntMax) begin
                    beat_cnt_d[c] = beat_cnt_q[c] + CNT_W'(1);
                end
            end
            if (beat[c]) begin
                last_data_d[c] = bus.data[c*DATA_W +: DATA_W];
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_valid_q <= '0;
            act_q        <= '0;
            rdy_q        <= '0;
            fell_q       <= '0;
            stall_cnt_q  <= '0;
            err_pulse_q  <= '0;
            err_sticky_q <= '0;
            err_cnt_q    <= '0;
            beat_cnt_q   <= '0;
            last_data_q  <= '0;
        end else begin
            prev_valid_q <= prev_valid_d;
            act_q        <= act_d;
            rdy_q        <= rdy_d;
            fell_q       <= fell_d;
            stall_cnt_q  <= stall_cnt_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            last_data_q  <= last_data_d;
        end
    end

    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign beat_cnt   = beat_cnt_q;
    assign last_data  = last_data_q;
endmodule

// File: tb/tb_bus_protocol_monitor.sv
// Bench for bus_protocol_monitor: two instances (default config and a small
// one with STALL_MAX=2, CNT_W=2) observe the same bus. A reference model built
// on sample history pushes expected outputs per edge; a monitor pops and compares.
module tb_bus_protocol_monitor;
    typedef struct packed {
        logic [1:0]      pulse;
        logic [7:0]      sticky;
        logic [1:0][7:0] ecnt;
        logic [1:0][7:0] bcnt;
        logic [1:0][7:0] last;
    } exp_t;

    bit clk;
    logic rst_n, mon_en, clr;
    logic [1:0]  err_pulse0, err_pulse1;
    logic [7:0]  err_sticky0, err_sticky1;
    logic [15:0] err_cnt0, beat_cnt0, last_data0, last_data1;
    logic [3:0]  err_cnt1, beat_cnt1;

    int total = 0;
    int bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    // Reference model state (index k = configuration, c = channel).
    int        smax[2]  = '{5, 2};
    int        cmax[2]  = '{255, 3};
    bit [3:0]  m_sticky[2][2];
    int        m_ecnt[2][2];
    int        m_bcnt[2][2];
    bit [7:0]  m_last[2][2];
    int        nsamp;
    int        run[2];      // uncapped length of the current stall run
    bit        h_act1[2], h_act2[2], h_rdy1[2];

    bus_protocol_monitor_if #(.NUM_CH(2), .DATA_W(8)) bus ();

    bus_protocol_monitor dut0 (
        .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .clr(clr), .bus(bus),
        .err_pulse(err_pulse0), .err_sticky(err_sticky0), .err_cnt(err_cnt0),
        .beat_cnt(beat_cnt0), .last_data(last_data0)
    );

    bus_protocol_monitor #(.NUM_CH(2), .DATA_W(8), .STALL_MAX(2), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .clr(clr), .bus(bus),
        .err_pulse(err_pulse1), .err_sticky(err_sticky1), .err_cnt(err_cnt1),
        .beat_cnt(beat_cnt1), .last_data(last_data1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected outputs after the next clock edge, given the inputs sampled there.
    task automatic model_step(input bit rn, input bit me, input bit cl, input logic [1:0] a,
                              input logic [1:0] r, input logic [1:0] oe,
                              input logic [15:0] d);
        exp_t e[2];
        bit [3:0] v;
        bit pv, bt;
        int stall;
        e[0] = '0;
        e[1] = '0;
        if (!rn) begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 2; c++) begin
                    m_sticky[k][c] = '0; m_ecnt[k][c] = 0; m_bcnt[k][c] = 0; m_last[k][c] = '0;
                end
            end
            nsamp = 0;
            for (int c = 0; c < 2; c++) begin
                run[c] = 0; h_act1[c] = 0; h_act2[c] = 0; h_rdy1[c] = 0;
            end
        end else begin
            pv = (nsamp > 0);
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 2; c++) begin
                    stall = (run[c] < smax[k]) ? run[c] : smax[k];
                    v[0] = (!a[c] || !r[c]) && oe[c];
                    v[1] = pv && (stall == smax[k]) && a[c];
                    v[2] = pv && !h_act1[c] && !h_rdy1[c] && r[c];
                    v[3] = pv && h_act2[c] && !h_act1[c] && r[c];
                    bt = me && a[c] && r[c] && oe[c];
                    if (!me) v = '0;
                    if (cl) begin
                        m_sticky[k][c] = '0; m_ecnt[k][c] = 0; m_bcnt[k][c] = 0;
                    end else begin
                        m_sticky[k][c] |= v;
                        if (v != 0 && m_ecnt[k][c] < cmax[k]) m_ecnt[k][c]++;
                        if (bt && m_bcnt[k][c] < cmax[k]) m_bcnt[k][c]++;
                    end
                    if (bt) m_last[k][c] = d[c*8 +: 8];
                    e[k].pulse[c]        = (v != 0);
                    e[k].sticky[4*c +: 4] = m_sticky[k][c];
                    e[k].ecnt[c]         = 8'(m_ecnt[k][c]);
                    e[k].bcnt[c]         = 8'(m_bcnt[k][c]);
                    e[k].last[c]         = m_last[k][c];
                end
            end
            for (int c = 0; c < 2; c++) begin
                h_act2[c] = h_act1[c];
                h_act1[c] = a[c];
                h_rdy1[c] = r[c];
                run[c]    = (a[c] && !r[c]) ? run[c] + 1 : 0;
            end
            nsamp++;
        end
        q0.push_back(e[0]);
        q1.push_back(e[1]);
    endtask

    // Apply one sample, record its expectation, and advance past the edge.
    task automatic cyc(input bit rn, input bit me, input bit cl, input logic [1:0] a,
                       input logic [1:0] r, input logic [1:0] oe, input logic [15:0] d);
        rst_n = rn; mon_en = me; clr = cl;
        bus.active = a; bus.ready = r; bus.data_oe = oe; bus.data = d;
        model_step(rn, me, cl, a, r, oe, d);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: outputs are presented every cycle, compared mid-cycle.
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (q0.size() > 0 && q1.size() > 0) begin
                e = q0.pop_front();
                chk("pulse0",  32'(err_pulse0),  32'(e.pulse));
                chk("sticky0", 32'(err_sticky0), 32'(e.sticky));
                chk("ecnt0",   32'(err_cnt0),    32'(e.ecnt));
                chk("bcnt0",   32'(beat_cnt0),   32'(e.bcnt));
                chk("last0",   32'(last_data0),  32'(e.last));
                e = q1.pop_front();
                chk("pulse1",  32'(err_pulse1),  32'(e.pulse));
                chk("sticky1", 32'(err_sticky1), 32'(e.sticky));
                chk("ecnt1",   32'(err_cnt1),    32'({e.ecnt[1][1:0], e.ecnt[0][1:0]}));
                chk("bcnt1",   32'(beat_cnt1),   32'({e.bcnt[1][1:0], e.bcnt[0][1:0]}));
                chk("last1",   32'(last_data1),  32'(e.last));
            end
        end
    end

    initial begin
        logic [1:0] a, r, oe;
        // Directed scenarios with hand-derived expectations on the default instance.
        repeat (2) cyc(0, 1, 0, 2'b00, 2'b00, 2'b00, 16'h0);
        chk("reset_sticky", 32'(err_sticky0), 32'h0);
        cyc(1, 1, 0, 2'b00, 2'b01, 2'b00, 16'h0);
        chk("first_no_r3", 32'(err_sticky0), 32'h0);
        cyc(1, 1, 0, 2'b00, 2'b00, 2'b00, 16'h0);
        cyc(1, 1, 0, 2'b00, 2'b01, 2'b00, 16'h0);
        chk("r3_sticky", 32'(err_sticky0), 32'h04);
        cyc(1, 1, 0, 2'b00, 2'b01, 2'b01, 16'h0);
        chk("r1_sticky", 32'(err_sticky0), 32'h05);
        chk("r1_cnt", 32'(err_cnt0), 32'h0002);
        repeat (5) cyc(1, 1, 0, 2'b10, 2'b00, 2'b00, 16'h0);
        chk("stall5_ok", 32'(err_cnt0[15:8]), 32'h0);
        repeat (3) cyc(1, 1, 0, 2'b10, 2'b00, 2'b00, 16'h0);
        chk("r2_cnt", 32'(err_cnt0[15:8]), 32'd3);
        chk("r2_sticky", 32'(err_sticky0[5]), 32'h1);
        repeat (2) cyc(1, 1, 0, 2'b00, 2'b00, 2'b00, 16'h0);
        repeat (3) cyc(1, 1, 0, 2'b01, 2'b01, 2'b01, 16'h00a5);
        chk("beat_cnt", 32'(beat_cnt0[7:0]), 32'd3);
        chk("last_data", 32'(last_data0[7:0]), 32'ha5);
        cyc(1, 1, 0, 2'b00, 2'b00, 2'b00, 16'h0);
        cyc(1, 1, 0, 2'b00, 2'b01, 2'b00, 16'h0);
        chk("r4_r3_sticky", 32'(err_sticky0[3:2]), 32'h3);
        cyc(1, 1, 1, 2'b00, 2'b01, 2'b01, 16'h0);
        chk("clr_pulse", 32'(err_pulse0), 32'h1);
        chk("clr_sticky", 32'(err_sticky0), 32'h0);
        chk("clr_cnt", 32'({err_cnt0, beat_cnt0}), 32'h0);
        cyc(1, 0, 0, 2'b00, 2'b01, 2'b01, 16'h0);
        chk("mon_off_pulse", 32'(err_pulse0), 32'h0);
        chk("mon_off_cnt", 32'(err_cnt0), 32'h0);
        repeat (5) cyc(1, 1, 0, 2'b01, 2'b01, 2'b01, 16'h003c);
        chk("sat_small", 32'(beat_cnt1[1:0]), 32'd3);
        chk("no_sat_big", 32'(beat_cnt0[7:0]), 32'd5);

        // Randomized traffic with sticky active so stalls and timeouts occur.
        a = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(3) == 0) a[c] = ~a[c];
                r[c]  = ($urandom_range(2) == 0);
                oe[c] = (a[c] && r[c]) ? ($urandom_range(7) != 0) : ($urandom_range(9) == 0);
            end
            cyc(($urandom_range(499) != 0), ($urandom_range(15) != 0),
                ($urandom_range(399) == 0), a, r, oe, 16'($urandom));
        end
        #10;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_protocol_monitor.md
Name: bus_protocol_monitor

Overview:
- Synthesizable, multi-channel protocol checker for the active/ready/data bus.
- Enforces four handshake rules per channel in hardware: data-drive, stall timeout, idle hold, and post-release.
- Reports per-channel sticky error flags, error pulses, error and beat counters, and last transferred data.
- Sits passively beside each bus slice: taps inputs only and never drives the bus.

Parameters:
- NUM_CH, 2: number of independent monitored channels.
- DATA_W, 8: data width per channel.
- STALL_MAX, 5: consecutive active&&!ready samples allowed before active must drop; range 1..255.
- CNT_W, 8: width of the per-channel error and beat counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- mon_en  input  1  enables rule evaluation and counting.
- clr  input  1  synchronous clear of sticky flags and counters.
- active  input  NUM_CH  per-channel active.
- ready  input  NUM_CH  per-channel ready.
- data_oe  input  NUM_CH  per-channel data driver enable (1 = bus driven, 0 = Z).
- data  input  NUM_CH*DATA_W  channel c at [c*DATA_W +: DATA_W].
- err_pulse  output  NUM_CH  one-cycle pulse when any rule is violated on the channel.
- err_sticky  output  4*NUM_CH  rule r (1..4) of channel c at bit 4*c+r-1.
- err_cnt  output  NUM_CH*CNT_W  saturating count of violating cycles per channel.
- beat_cnt  output  NUM_CH*CNT_W  saturating count of transfer beats per channel.
- last_data  output  NUM_CH*DATA_W  data captured at the most recent beat per channel.

Behaviour:
- All state updates on posedge clk. Channels are fully independent; each holds:
  - prev_valid (1 bit)
  - act_q, rdy_q: previous-sample registers
  - fell_q: active fell at the previous sample
  - stall_cnt: 0..STALL_MAX, saturating
- rst_n=0 at a clock edge: every output = 0; prev_valid = act_q = rdy_q = fell_q = stall_cnt = 0. Reset mid-stall discards stall history.
- History update every non-reset edge, regardless of mon_en:
  - act_q <= active; rdy_q <= ready; prev_valid <= 1; fell_q <= act_q && !active.
  - stall_cnt <= (active && !ready) ? min(stall_cnt+1, STALL_MAX) : 0.
- Rules, evaluated on current sample S when mon_en=1:
  - R1: (!active || !ready) && data_oe → violation.
  - R2: prev_valid && stall_cnt == STALL_MAX && active → violation. Repeats every cycle while active stays high.
  - R3: prev_valid && !act_q && !rdy_q && ready → violation.
  - R4: prev_valid && fell_q && ready → violation.
  - On the first sample after reset (prev_valid=0), only R1 is evaluated.
- Latency: err_pulse[c] is registered and high for exactly the cycle after the violating edge.
- err_sticky bit is set on violation and held until clr or reset.
- err_cnt increments by 1 per violating cycle, even when several rules fire at once, and saturates at 2^CNT_W-1.
- Beat: active && ready && data_oe with mon_en=1. On a beat, beat_cnt increments (saturating) and last_data captures data, visible the following cycle.
- mon_en=0: no violations and no beats. Flags and counters hold; history still updates.
- clr=1: err_sticky, err_cnt and beat_cnt go to 0 next cycle.
  - clr takes priority over a same-cycle set or increment.
  - err_pulse still fires for a violation sampled in that cycle.
  - last_data and history are unaffected.
- rst_n=0 overrides clr and mon_en.

Test Plan:
- Reset/first sample: rst_n=0 for 2 cycles, release with ch0 active=0, ready=1 → all outputs 0, no R3 on the first sample; if active=0, ready=0 follows, the next ready=1 flags R3.
- R1: ch0 active=0, ready=1, data_oe=1 for 1 cycle → err_pulse[0]=1 for 1 cycle, err_sticky[0]=1, err_cnt ch0=1; ch1 unaffected.
- R2 timeout: ch1 active=1, ready=0 for 5 samples, then active=1 a 6th sample → err_sticky[5]=1. Holding 2 more cycles → err_cnt ch1=3. Dropping active at the 6th sample instead → no error.
- R4 + beat: ch0 active=1, ready=1, data_oe=1, data=0xA5 for 3 cycles → beat_cnt=3, last_data=0xA5. Then active=0 and next sample ready=1 → err_sticky[3]=1 (R4), plus R3 if ready was 0.
- clr priority: R1 violation and clr=1 in the same cycle → err_pulse=1, err_sticky and err_cnt = 0 after the edge.
- Saturation/mon_en: with CNT_W=2, run 5 beats → beat_cnt=3. With mon_en=0, inject R1 → no pulse, counters hold.
